phase_accumulator_nco: RTL and testbench



---
 rtl/phase_accumulator_nco.sv | 83 ++++++++
 tb/tb_phase_accumulator_nco.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator_nco.sv
// Tick-driven phase accumulator NCO with a double-buffered frequency control word.
// A new FCW is applied only at a phase wrap, while stopped, or on sync_clr, so the output never glitches mid-period.
module phase_accumulator_nco #(
    parameter int               ACC_W       = 16,
    parameter int               PH_W        = 8,
    parameter logic [ACC_W-1:0] FCW_DEFAULT = 16'd256,
    parameter int               WCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              sync_clr,
    input  logic [ACC_W-1:0]  fcw_in,
    input  logic              fcw_valid,
    output logic              fcw_ready,
    output logic [PH_W-1:0]   phase,
    output logic              sq_out,
    output logic              wrap,
    output logic [WCNT_W-1:0] wrap_count,
    output logic [ACC_W-1:0]  fcw_active
);

    // Unsigned modulo add; the extra MSB carries the wrap indication.
    function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             stopped;
    logic [ACC_W-1:0] pend_fcw;
    logic             pend_valid;
    logic             apply;
    logic             capture;

    assign sum       = add_wrap(acc, fcw_active);
    assign carry     = sum[ACC_W];
    assign stopped   = (fcw_active == '0);
    assign fcw_ready = ~pend_valid;
    assign capture   = fcw_valid & ~pend_valid;
    // A stopped oscillator never wraps, so any tick must be allowed to release the pending word.
    assign apply     = pend_valid & (sync_clr | (tick & (carry | stopped)));

    assign phase  = acc[ACC_W-1 -: PH_W];
    assign sq_out = acc[ACC_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            wrap       <= 1'b0;
            wrap_count <= '0;
        end else if (sync_clr) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (tick) begin
            acc  <= sum[ACC_W-1:0];
            wrap <= carry;
            if (carry) begin
                wrap_count <= wrap_count + {{(WCNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Apply and capture are mutually exclusive because ready is low while pending is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_active <= FCW_DEFAULT;
            pend_fcw   <= '0;
            pend_valid <= 1'b0;
        end else if (apply) begin
            fcw_active <= pend_fcw;
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend_fcw   <= fcw_in;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_accumulator_nco.sv
// Directed bench for phase_accumulator_nco with default parameters (ACC_W=16, PH_W=8, FCW_DEFAULT=256, WCNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_phase_accumulator_nco;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        sync_clr;
    logic [15:0] fcw_in;
    logic        fcw_valid;
    logic        fcw_ready;
    logic [7:0]  phase;
    logic        sq_out;
    logic        wrap;
    logic [7:0]  wrap_count;
    logic [15:0] fcw_active;

    int n_tests = 0;
    int n_fail  = 0;

    phase_accumulator_nco dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sync_clr   (sync_clr),
        .fcw_in     (fcw_in),
        .fcw_valid  (fcw_valid),
        .fcw_ready  (fcw_ready),
        .phase      (phase),
        .sq_out     (sq_out),
        .wrap       (wrap),
        .wrap_count (wrap_count),
        .fcw_active (fcw_active)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One valid/ready transfer; ready must be high before and low after.
    task automatic send_fcw(input logic [15:0] value, input string tag);
        fcw_in    = value;
        fcw_valid = 1'b1;
        chk({tag, "_ready_before"}, 32'(fcw_ready), 32'd1);
        cyc();
        fcw_valid = 1'b0;
        chk({tag, "_ready_after"}, 32'(fcw_ready), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        tick      = 1'b0;
        sync_clr  = 1'b0;
        fcw_in    = 16'h0000;
        fcw_valid = 1'b0;

        // Asynchronous reset before the first rising edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_phase", 32'(phase), 32'h00);
        chk("rst_sq", 32'(sq_out), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_wcnt", 32'(wrap_count), 32'd0);
        chk("rst_fcw_active", 32'(fcw_active), 32'h0100);
        chk("rst_ready", 32'(fcw_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        cyc();

        // Steady counting with FCW=256: phase steps by 1, one wrap after tick 256.
        tick = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            chk("steady_phase", 32'(phase), 32'(k % 256));
            chk("steady_wrap", 32'(wrap), (k == 256) ? 32'd1 : 32'd0);
            if (k == 127) chk("steady_sq_low", 32'(sq_out), 32'd0);
            if (k == 128) chk("steady_sq_high", 32'(sq_out), 32'd1);
        end
        tick = 1'b0;
        chk("steady_wcnt", 32'(wrap_count), 32'd1);
        cyc();
        chk("steady_wrap_drop", 32'(wrap), 32'd0);
        chk("steady_hold_phase", 32'(phase), 32'h00);

        // Deferred update: acc=0xFF00, then load 0x1000 which applies at the next wrap.
        tick = 1'b1;
        repeat (255) cyc();
        tick = 1'b0;
        chk("defer_phase_ff", 32'(phase), 32'hFF);
        chk("defer_wrap_pre", 32'(wrap), 32'd0);
        send_fcw(16'h1000, "defer");
        chk("defer_active_old", 32'(fcw_active), 32'h0100);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("defer_wrap_phase", 32'(phase), 32'h00);
        chk("defer_wrap", 32'(wrap), 32'd1);
        chk("defer_wcnt", 32'(wrap_count), 32'd2);
        chk("defer_active_new", 32'(fcw_active), 32'h1000);
        chk("defer_ready_back", 32'(fcw_ready), 32'd1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("defer_next_phase", 32'(phase), 32'h10);
        chk("defer_next_wrap", 32'(wrap), 32'd0);

        // Stopped oscillator: FCW=0 via sync_clr, then 0x0010 applies on the first tick.
        send_fcw(16'h0000, "stop_zero");
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        chk("stop_clr_phase", 32'(phase), 32'h00);
        chk("stop_clr_active", 32'(fcw_active), 32'h0000);
        chk("stop_clr_ready", 32'(fcw_ready), 32'd1);
        chk("stop_clr_wcnt", 32'(wrap_count), 32'd2);
        send_fcw(16'h0010, "stop_load");
        chk("stop_active_held", 32'(fcw_active), 32'h0000);
        tick = 1'b1;
        cyc();
        chk("stop_apply_active", 32'(fcw_active), 32'h0010);
        chk("stop_apply_phase", 32'(phase), 32'h00);
        chk("stop_apply_ready", 32'(fcw_ready), 32'd1);
        chk("stop_apply_wrap", 32'(wrap), 32'd0);
        repeat (15) cyc();
        chk("stop_acc_f0", 32'(phase), 32'h00);
        cyc();
        tick = 1'b0;
        chk("stop_acc_100", 32'(phase), 32'h01);

        // Priority: acc=0xFFF0 with FCW=0x10 (tick alone would wrap), pending 0x20, tick+sync_clr.
        tick = 1'b1;
        repeat (4079) cyc();
        tick = 1'b0;
        chk("prio_phase_pre", 32'(phase), 32'hFF);
        chk("prio_wrap_pre", 32'(wrap), 32'd0);
        send_fcw(16'h0020, "prio");
        tick     = 1'b1;
        sync_clr = 1'b1;
        cyc();
        tick     = 1'b0;
        sync_clr = 1'b0;
        chk("prio_phase", 32'(phase), 32'h00);
        chk("prio_sq", 32'(sq_out), 32'd0);
        chk("prio_wrap", 32'(wrap), 32'd0);
        chk("prio_wcnt", 32'(wrap_count), 32'd2);
        chk("prio_active", 32'(fcw_active), 32'h0020);
        chk("prio_ready", 32'(fcw_ready), 32'd1);
        cyc();
        chk("prio_wrap_after", 32'(wrap), 32'd0);

        // Wrap-count rollover: FCW=0x8000 wraps every second tick; 256 wraps bring the count back.
        send_fcw(16'h8000, "roll");
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        chk("roll_active", 32'(fcw_active), 32'h8000);
        chk("roll_phase0", 32'(phase), 32'h00);
        tick = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            if (i == 512) begin
                fcw_in    = 16'h1234;
                fcw_valid = 1'b1;
            end
            cyc();
            chk("roll_wrap", 32'(wrap), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("roll_wcnt", 32'(wrap_count), 32'((2 + i / 2) % 256));
            chk("roll_sq", 32'(sq_out), 32'(i % 2));
        end
        tick      = 1'b0;
        fcw_valid = 1'b0;
        chk("roll_wcnt_back", 32'(wrap_count), 32'd2);
        chk("roll_pend_full", 32'(fcw_ready), 32'd0);

        // Reset mid-operation with a wrap pulse in flight and a pending FCW.
        #1 rst = 1'b1;
        #1;
        chk("midrst_wrap", 32'(wrap), 32'd0);
        chk("midrst_wcnt", 32'(wrap_count), 32'd0);
        chk("midrst_ready", 32'(fcw_ready), 32'd1);
        chk("midrst_active", 32'(fcw_active), 32'h0100);
        chk("midrst_phase", 32'(phase), 32'h00);
        @(negedge clk) rst = 1'b0;
        cyc();
        chk("postrst_ready", 32'(fcw_ready), 32'd1);
        chk("postrst_active", 32'(fcw_active), 32'h0100);
        chk("postrst_wrap", 32'(wrap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
